// File: rtl/adc_dac_seq.sv
// Round-robin SAR sequencer for the 4-channel shared ADC/DAC analog macro.
// Optional continuous rescan is enabled by defining ADC_AUTOSCAN_EN (adds cfg_auto).
module adc_dac_seq #(
   parameter int unsigned SAMPLE_CYC = 8,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic       mclk,
   input  logic       reset,
`ifdef ADC_AUTOSCAN_EN
   input  logic       cfg_auto,
`endif
   input  logic [3:0] cfg_sel,
   input  logic [7:0] cfg_dac0,
   input  logic [7:0] cfg_dac1,
   input  logic [7:0] cfg_dac2,
   input  logic [7:0] cfg_dac3,
   input  logic [3:0] conv_req,
   output logic       conv_busy,
   output logic [3:0] conv_done,
   output logic [7:0] adc_data0,
   output logic [7:0] adc_data1,
   output logic [7:0] adc_data2,
   output logic [7:0] adc_data3,
   output logic [7:0] dac_din0,
   output logic [7:0] dac_din1,
   output logic [7:0] dac_din2,
   output logic [7:0] dac_din3,
   output logic [3:0] adc_sample,
   input  logic [3:0] adc_result,
   output logic [3:0] adc_sel
);

   localparam int unsigned CNT_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL, DONE} state_t;

   state_t        state;
   logic [1:0]    ch;
   logic [1:0]    rr;
   logic [3:0]    pending;
   logic [CW-1:0] cnt;
   logic [2:0]    bitn;
   logic [7:0]    sar;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [7:0]    din_q  [4];
   logic [7:0]    data_q [4];
   logic [7:0]    cfg_dac [4];

   logic [3:0]    req_eff;
   logic [3:0]    req_new;
   logic [1:0]    pick;
   logic          pick_valid;
   logic [1:0]    idx;
   logic [7:0]    trial_bit;
   logic [7:0]    kept_sar;

   assign cfg_dac[0] = cfg_dac0;
   assign cfg_dac[1] = cfg_dac1;
   assign cfg_dac[2] = cfg_dac2;
   assign cfg_dac[3] = cfg_dac3;

   assign dac_din0  = din_q[0];
   assign dac_din1  = din_q[1];
   assign dac_din2  = din_q[2];
   assign dac_din3  = din_q[3];
   assign adc_data0 = data_q[0];
   assign adc_data1 = data_q[1];
   assign adc_data2 = data_q[2];
   assign adc_data3 = data_q[3];

   assign req_new = conv_req & cfg_sel;
`ifdef ADC_AUTOSCAN_EN
   assign req_eff = pending | (cfg_auto ? cfg_sel : 4'b0000);
`else
   assign req_eff = pending;
`endif

   assign trial_bit = 8'(1) << bitn;
   assign kept_sar  = sync2[ch] ? (sar | trial_bit) : sar;

   // Search rr+1, rr+2, rr+3, rr (mod 4); the lowest offset wins.
   always_comb begin
      pick       = 2'd0;
      pick_valid = 1'b0;
      idx        = 2'd0;
      for (int i = 4; i >= 1; i--) begin
         idx = rr + 2'(i);
         if (req_eff[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state      <= IDLE;
         ch         <= 2'd0;
         rr         <= 2'd0;
         pending    <= 4'b0000;
         cnt        <= '0;
         bitn       <= 3'd0;
         sar        <= 8'h00;
         sync1      <= 4'b0000;
         sync2      <= 4'b0000;
         conv_busy  <= 1'b0;
         conv_done  <= 4'b0000;
         adc_sample <= 4'b0000;
         adc_sel    <= 4'b0000;
         for (int n = 0; n < 4; n++) begin
            din_q[n]  <= 8'h00;
            data_q[n] <= 8'h00;
         end
      end else begin
         sync1     <= adc_result;
         sync2     <= sync1;
         adc_sel   <= cfg_sel;
         conv_done <= 4'b0000;
         pending   <= pending | req_new;
         // Idle ADC channels park at 0, DAC channels follow their config code.
         for (int n = 0; n < 4; n++) begin
            din_q[n] <= cfg_sel[n] ? 8'h00 : cfg_dac[n];
         end

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  ch         <= pick;
                  rr         <= pick;
                  pending    <= (pending & ~(4'(1) << pick)) | req_new;
                  adc_sample <= 4'(1) << pick;
                  conv_busy  <= 1'b1;
                  cnt        <= '0;
                  state      <= SAMPLE;
               end
            end
            SAMPLE, TRIAL: begin
               if (!cfg_sel[ch]) begin
                  // Channel switched back to DAC mode: abandon without a result.
                  state      <= IDLE;
                  conv_busy  <= 1'b0;
                  adc_sample <= 4'b0000;
                  pending    <= (pending | req_new) & ~(4'(1) << ch);
               end else if (state == SAMPLE) begin
                  if (cnt == CW'(SAMPLE_CYC - 1)) begin
                     state      <= TRIAL;
                     adc_sample <= 4'b0000;
                     sar        <= 8'h00;
                     bitn       <= 3'd7;
                     cnt        <= '0;
                     din_q[ch]  <= 8'h80;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  if (cnt == CW'(SETTLE_CYC - 1)) begin
                     sar <= kept_sar;
                     cnt <= '0;
                     if (bitn == 3'd0) begin
                        state      <= DONE;
                        conv_done  <= 4'(1) << ch;
                        data_q[ch] <= kept_sar;
                     end else begin
                        bitn      <= bitn - 3'd1;
                        din_q[ch] <= kept_sar | (8'(1) << (bitn - 3'd1));
                     end
                  end else begin
                     cnt       <= cnt + CW'(1);
                     din_q[ch] <= sar | trial_bit;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               conv_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_dac_seq.sv
// Directed bench for adc_dac_seq with a behavioural comparator per channel.
module tb_adc_dac_seq;

   logic       mclk;
   logic       reset;
   logic [3:0] cfg_sel;
   logic [7:0] cfg_dac0, cfg_dac1, cfg_dac2, cfg_dac3;
   logic [3:0] conv_req;
   logic       conv_busy;
   logic [3:0] conv_done;
   logic [7:0] adc_data0, adc_data1, adc_data2, adc_data3;
   logic [7:0] dac_din0, dac_din1, dac_din2, dac_din3;
   logic [3:0] adc_sample;
   logic [3:0] adc_result;
   logic [3:0] adc_sel;

   logic [7:0] vin [4];

   int n_checks = 0;
   int n_fail   = 0;

   adc_dac_seq dut (
      .mclk(mclk), .reset(reset),
`ifdef ADC_AUTOSCAN_EN
      .cfg_auto(1'b0),
`endif
      .cfg_sel(cfg_sel),
      .cfg_dac0(cfg_dac0), .cfg_dac1(cfg_dac1), .cfg_dac2(cfg_dac2), .cfg_dac3(cfg_dac3),
      .conv_req(conv_req), .conv_busy(conv_busy), .conv_done(conv_done),
      .adc_data0(adc_data0), .adc_data1(adc_data1), .adc_data2(adc_data2), .adc_data3(adc_data3),
      .dac_din0(dac_din0), .dac_din1(dac_din1), .dac_din2(dac_din2), .dac_din3(dac_din3),
      .adc_sample(adc_sample), .adc_result(adc_result), .adc_sel(adc_sel)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // Analog input sits half an LSB above its code, so code c converts to exactly c.
   assign adc_result[0] = (vin[0] >= dac_din0);
   assign adc_result[1] = (vin[1] >= dac_din1);
   assign adc_result[2] = (vin[2] >= dac_din2);
   assign adc_result[3] = (vin[3] >= dac_din3);

   task automatic step(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] data_of(input int c);
      case (c)
         0: return adc_data0;
         1: return adc_data1;
         2: return adc_data2;
         default: return adc_data3;
      endcase
   endfunction

   task automatic pulse_req(input logic [3:0] r);
      conv_req = r;
      step(1);
      conv_req = 4'b0000;
   endtask

   task automatic wait_sample(input int c, input int bound, output int cyc);
      cyc = 0;
      while (!adc_sample[c] && cyc < bound) begin step(1); cyc++; end
      if (!adc_sample[c]) cyc = -1;
   endtask

   task automatic wait_done_any(input int bound, output int cyc);
      cyc = 0;
      while (conv_done == 4'b0000 && cyc < bound) begin step(1); cyc++; end
      if (conv_done == 4'b0000) cyc = -1;
   endtask

   initial begin
      int cyc;
      int hi;
      int lat;
      logic [3:0] seen;
      int order [4];
      logic [7:0] exp_v [4];

      reset = 1'b1; cfg_sel = 4'b0000; conv_req = 4'b0000;
      cfg_dac0 = 8'h00; cfg_dac1 = 8'h00; cfg_dac2 = 8'h00; cfg_dac3 = 8'h00;
      for (int i = 0; i < 4; i++) vin[i] = 8'h00;
      step(3);
      check("rst_busy", 32'(conv_busy), 32'h0);
      check("rst_done", 32'(conv_done), 32'h0);
      check("rst_sample", 32'(adc_sample), 32'h0);
      check("rst_sel", 32'(adc_sel), 32'h0);
      check("rst_din0", 32'(dac_din0), 32'h0);
      check("rst_data0", 32'(adc_data0), 32'h0);

      // Channel 0 conversion of 0xA5: sample width, latency, result.
      reset = 1'b0; cfg_sel = 4'b0001; vin[0] = 8'hA5;
      step(1);
      check("sel_latency", 32'(adc_sel), 32'h1);
      pulse_req(4'b0001);
      wait_sample(0, 10, cyc);
      check("ch0_sample_start", 32'(cyc >= 0), 32'h1);
      check("ch0_busy", 32'(conv_busy), 32'h1);
      check("ch0_din_sample", 32'(dac_din0), 32'h0);
      hi = 0; lat = 0;
      while (!conv_done[0] && lat < 100) begin
         if (adc_sample[0]) hi++;
         step(1); lat++;
      end
      check("ch0_sample_cycles", 32'(hi), 32'd8);
      check("ch0_latency", 32'(lat), 32'd40);
      check("ch0_data", 32'(adc_data0), 32'hA5);
      check("ch0_busy_done", 32'(conv_busy), 32'h1);
      step(1);
      check("ch0_done_pulse", 32'(conv_done), 32'h0);
      check("ch0_busy_end", 32'(conv_busy), 32'h0);

      // Channel 2 boundary codes.
      cfg_sel = 4'b0100; vin[2] = 8'hFF;
      pulse_req(4'b0100);
      wait_done_any(80, cyc);
      check("ch2_ff_done", 32'(conv_done), 32'h4);
      check("ch2_ff_data", 32'(adc_data2), 32'hFF);
      step(1);
      vin[2] = 8'h00;
      pulse_req(4'b0100);
      wait_done_any(80, cyc);
      check("ch2_00_done", 32'(conv_done), 32'h4);
      check("ch2_00_data", 32'(adc_data2), 32'h00);
      step(1);

      // DAC mode pass-through; requests dropped.
      cfg_sel = 4'b0000; cfg_dac1 = 8'h3C;
      step(1);
      check("dac1_out", 32'(dac_din1), 32'h3C);
      pulse_req(4'b0010);
      step(3);
      check("dac1_no_busy", 32'(conv_busy), 32'h0);
      check("dac1_no_done", 32'(conv_done), 32'h0);

      // Four simultaneous requests after reset: served 1,2,3,0.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      cfg_sel = 4'b1111;
      vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33; vin[3] = 8'h44;
      order[0] = 1; order[1] = 2; order[2] = 3; order[3] = 0;
      exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33; exp_v[3] = 8'h44;
      pulse_req(4'b1111);
      for (int k = 0; k < 4; k++) begin
         wait_done_any(80, cyc);
         check($sformatf("rr_done_%0d", k), 32'(conv_done), 32'(4'(1) << order[k]));
         check($sformatf("rr_data_%0d", k), 32'(data_of(order[k])), 32'(exp_v[order[k]]));
         step(1);
      end

      // Abort channel 3 mid-trial.
      cfg_sel = 4'b1000; cfg_dac3 = 8'h5A; vin[3] = 8'h77;
      pulse_req(4'b1000);
      wait_sample(3, 10, cyc);
      check("ab_sample_start", 32'(cyc >= 0), 32'h1);
      step(14);
      check("ab_busy_trial", 32'(conv_busy), 32'h1);
      cfg_sel = 4'b0000;
      step(1);
      check("ab_idle", 32'(conv_busy), 32'h0);
      check("ab_din3", 32'(dac_din3), 32'h5A);
      seen = 4'b0000;
      for (int i = 0; i < 50; i++) begin
         seen = seen | conv_done;
         step(1);
      end
      check("ab_no_done", 32'(seen), 32'h0);
      check("ab_data3", 32'(adc_data3), 32'h44);

      // Reset in the middle of a trial, then a clean conversion.
      cfg_sel = 4'b0001; vin[0] = 8'h5C;
      pulse_req(4'b0001);
      wait_sample(0, 10, cyc);
      step(15);
      check("mr_busy_pre", 32'(conv_busy), 32'h1);
      reset = 1'b1;
      step(1);
      check("mr_busy", 32'(conv_busy), 32'h0);
      check("mr_sample", 32'(adc_sample), 32'h0);
      check("mr_sel", 32'(adc_sel), 32'h0);
      check("mr_din0", 32'(dac_din0), 32'h0);
      check("mr_data0", 32'(adc_data0), 32'h0);
      reset = 1'b0;
      pulse_req(4'b0001);
      wait_done_any(80, cyc);
      check("mr_done", 32'(conv_done), 32'h1);
      check("mr_data", 32'(adc_data0), 32'h5C);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
